// File: rtl/m_dram_responder.sv
// m_dram_responder: fixed-latency on-chip DRAM model behind the MMU port.
// Byte/half/word loads and stores on an internal word array.
module m_dram_responder #(
   parameter int MEM_WORDS = 4096,
   parameter int LATENCY   = 3
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] w_dram_addr,
   input  logic [31:0] w_dram_wdata,
   input  logic        w_dram_we_t,
   input  logic        w_dram_le,
   input  logic [2:0]  w_dram_ctrl,
   output logic [31:0] w_dram_odata,
   output logic        w_dram_busy,
   output logic        w_misalign
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW+1:0]   addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     odata_q, odata_d;
   logic [2:0]      ctrl_q, ctrl_d;
   logic            ld_q, ld_d;
   logic            st_q, st_d;
   logic            busy_q, busy_d;
   logic            mis_q, mis_d;

   logic [31:0]     mem [MEM_WORDS];
   logic [AW-1:0]   idx;
   logic [31:0]     word;
   logic [31:0]     st_word;
   logic [31:0]     st_mask;
   logic [31:0]     wr_word;
   logic            fire;
   logic            mis_now;
   logic            unused_addr;

   assign unused_addr = ^w_dram_addr[31:AW+2];

   assign idx  = addr_q[AW+1:2];
   assign word = mem[idx];
   assign fire = (state_q == BUSY) && (cnt_q == '0);

   function automatic logic [31:0] fmt(
      input logic [31:0] w,
      input logic [2:0]  c,
      input logic [1:0]  a
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] f;
      b = 8'(w >> {a, 3'b000});
      h = 16'(w >> {a[1], 4'b0000});
      unique case (c)
         3'd0:    f = {{24{b[7]}}, b};
         3'd1:    f = {{16{h[15]}}, h};
         3'd4:    f = {24'd0, b};
         3'd5:    f = {16'd0, h};
         default: f = w;
      endcase
      return f;
   endfunction

   // Lane select for stores; ctrl 3..7 on a store writes the full word.
   always_comb begin
      st_mask = 32'hFFFF_FFFF;
      st_word = wdata_q;
      if (ctrl_q == 3'd0) begin
         st_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
         st_word = {4{wdata_q[7:0]}};
      end else if (ctrl_q == 3'd1) begin
         st_mask = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
         st_word = {2{wdata_q[15:0]}};
      end
      wr_word = (word & ~st_mask) | (st_word & st_mask);
   end

   always_comb begin
      mis_now = 1'b0;
      if (w_dram_le) begin
         unique case (w_dram_ctrl)
            3'd0, 3'd4: mis_now = 1'b0;
            3'd1, 3'd5: mis_now = w_dram_addr[0];
            default:    mis_now = |w_dram_addr[1:0];
         endcase
      end else if (w_dram_ctrl == 3'd1) begin
         mis_now = w_dram_addr[0];
      end else if (w_dram_ctrl != 3'd0) begin
         mis_now = |w_dram_addr[1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ctrl_d  = ctrl_q;
      ld_d    = ld_q;
      st_d    = st_q;
      odata_d = odata_q;
      mis_d   = mis_q;
      unique case (state_q)
         IDLE: begin
            if (w_dram_le || w_dram_we_t) begin
               addr_d  = w_dram_addr[AW+1:0];
               wdata_d = w_dram_wdata;
               ctrl_d  = w_dram_ctrl;
               ld_d    = w_dram_le;
               st_d    = w_dram_we_t;
               cnt_d   = CW'(LATENCY - 1);
               mis_d   = mis_q | mis_now;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               if (ld_q) odata_d = fmt(word, ctrl_q, addr_q[1:0]);
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      endcase
      busy_d = (state_d == BUSY);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         ctrl_q  <= '0;
         ld_q    <= 1'b0;
         st_q    <= 1'b0;
         odata_q <= '0;
         busy_q  <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ctrl_q  <= ctrl_d;
         ld_q    <= ld_d;
         st_q    <= st_d;
         odata_q <= odata_d;
         busy_q  <= busy_d;
         mis_q   <= mis_d;
      end
   end

   // Array is never reset; a reset mid-transaction drops the store.
   always_ff @(posedge CLK) begin
      if (!RST && fire && st_q) mem[idx] <= wr_word;
   end

   assign w_dram_odata = odata_q;
   assign w_dram_busy  = busy_q;
   assign w_misalign   = mis_q;
endmodule

// File: tb/tb_m_dram_responder.sv
// tb_m_dram_responder: directed vectors against a transaction-level model
// of the DRAM responder, compared every cycle, plus literal expectations.
module tb_m_dram_responder;
   localparam int MW  = 4096;
   localparam int LAT = 3;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] w_dram_addr = '0;
   logic [31:0] w_dram_wdata = '0;
   logic        w_dram_we_t = 1'b0;
   logic        w_dram_le = 1'b0;
   logic [2:0]  w_dram_ctrl = '0;
   logic [31:0] w_dram_odata;
   logic        w_dram_busy;
   logic        w_misalign;

   int n_run = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   m_dram_responder #(.MEM_WORDS(MW), .LATENCY(LAT)) dut (
      .CLK(CLK),
      .RST(RST),
      .w_dram_addr(w_dram_addr),
      .w_dram_wdata(w_dram_wdata),
      .w_dram_we_t(w_dram_we_t),
      .w_dram_le(w_dram_le),
      .w_dram_ctrl(w_dram_ctrl),
      .w_dram_odata(w_dram_odata),
      .w_dram_busy(w_dram_busy),
      .w_misalign(w_misalign)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   logic [31:0] mm [MW];
   int          edge_n = 0;
   int          done_e = -1;
   logic        exp_busy = 1'b0;
   logic [31:0] exp_odata = '0;
   logic        exp_mis = 1'b0;
   logic        p_ld = 1'b0;
   logic        p_st = 1'b0;
   logic [2:0]  p_c = '0;
   logic [31:0] p_a = '0;
   logic [31:0] p_wd = '0;

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % MW);
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] w,
      input logic [2:0] c, input logic [31:0] a);
      logic signed [31:0] s;
      int bo;
      bo = int'(a % 4);
      case (c)
         3'd0: begin s = w << (24 - 8 * bo); return s >>> 24; end
         3'd1: begin s = w << (16 - 16 * (bo / 2)); return s >>> 16; end
         3'd4: return (w >> (8 * bo)) & 32'hFF;
         3'd5: return (w >> (16 * (bo / 2))) & 32'hFFFF;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] m_store(input logic [31:0] old,
      input logic [31:0] wd, input logic [2:0] c, input logic [31:0] a);
      logic [31:0] m;
      int sh;
      sh = 0;
      m  = 32'hFFFF_FFFF;
      if (c == 3'd0) begin
         sh = 8 * int'(a % 4);
         m  = 32'hFF << sh;
      end else if (c == 3'd1) begin
         sh = 16 * int'((a % 4) / 2);
         m  = 32'hFFFF << sh;
      end
      return (old & ~m) | ((wd << sh) & m);
   endfunction

   function automatic logic m_mis(input logic ld, input logic [2:0] c,
                                  input logic [31:0] a);
      int bo;
      bo = int'(a % 4);
      if (ld) begin
         if (c == 3'd0 || c == 3'd4) return 1'b0;
         if (c == 3'd1 || c == 3'd5) return (bo % 2) != 0;
         return bo != 0;
      end
      if (c == 3'd0) return 1'b0;
      if (c == 3'd1) return (bo % 2) != 0;
      return bo != 0;
   endfunction

   always @(posedge CLK) begin
      edge_n <= edge_n + 1;
      if (RST) begin
         exp_busy  <= 1'b0;
         exp_odata <= '0;
         exp_mis   <= 1'b0;
         done_e    <= -1;
      end else if (exp_busy && edge_n == done_e) begin
         if (p_st) mm[widx(p_a)] <= m_store(mm[widx(p_a)], p_wd, p_c, p_a);
         if (p_ld) exp_odata <= m_load(mm[widx(p_a)], p_c, p_a);
         exp_busy <= 1'b0;
      end else if (!exp_busy && (w_dram_le || w_dram_we_t)) begin
         p_ld     <= w_dram_le;
         p_st     <= w_dram_we_t;
         p_c      <= w_dram_ctrl;
         p_a      <= w_dram_addr;
         p_wd     <= w_dram_wdata;
         done_e   <= edge_n + LAT;
         exp_busy <= 1'b1;
         if (m_mis(w_dram_le, w_dram_ctrl, w_dram_addr)) exp_mis <= 1'b1;
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("cyc_busy", {31'd0, w_dram_busy}, {31'd0, exp_busy});
         chk("cyc_odata", w_dram_odata, exp_odata);
         chk("cyc_misalign", {31'd0, w_misalign}, {31'd0, exp_mis});
      end
   end

   // ---------------- stimulus ----------------
   task automatic tx(input logic le, input logic we, input logic [2:0] c,
                     input logic [31:0] a, input logic [31:0] wd,
                     output int nb);
      @(negedge CLK);
      w_dram_le    = le;
      w_dram_we_t  = we;
      w_dram_ctrl  = c;
      w_dram_addr  = a;
      w_dram_wdata = wd;
      @(negedge CLK);
      w_dram_le   = 1'b0;
      w_dram_we_t = 1'b0;
      nb = 0;
      while (w_dram_busy && nb < 20) begin
         nb++;
         @(negedge CLK);
      end
      if (nb >= 20) begin
         n_run++;
         n_fail++;
         $display("FAIL tx_timeout: got busy for %0d cycles, required %0d",
                  nb, LAT);
      end
   endtask

   logic [31:0] seq_val [3];

   initial begin
      int nb;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      chk_en = 1'b1;
      chk("rst_busy", {31'd0, w_dram_busy}, 32'd0);
      chk("rst_odata", w_dram_odata, 32'd0);
      chk("rst_misalign", {31'd0, w_misalign}, 32'd0);

      // 1: plain word load, latency
      tx(0, 1, 3'd2, 32'h8000_0010, 32'hDEAD_BEEF, nb);
      tx(1, 0, 3'd2, 32'h8000_0010, 32'h0, nb);
      chk("t1_busy_cycles", nb, 32'd3);
      chk("t1_lw", w_dram_odata, 32'hDEAD_BEEF);

      // 2: byte store into a word, then W/B/BU loads
      tx(0, 1, 3'd2, 32'h8000_0010, 32'h1122_3344, nb);
      tx(0, 1, 3'd0, 32'h8000_0013, 32'h0000_00A5, nb);
      chk("t2_sb_keeps_odata", w_dram_odata, 32'hDEAD_BEEF);
      tx(1, 0, 3'd2, 32'h8000_0013, 32'h0, nb);
      chk("t2_lw", w_dram_odata, 32'hA522_3344);
      tx(1, 0, 3'd0, 32'h8000_0013, 32'h0, nb);
      chk("t2_lb", w_dram_odata, 32'hFFFF_FFA5);
      tx(1, 0, 3'd4, 32'h8000_0013, 32'h0, nb);
      chk("t2_lbu", w_dram_odata, 32'h0000_00A5);

      // 3: upper half store
      tx(0, 1, 3'd2, 32'h4, 32'h0, nb);
      tx(0, 1, 3'd1, 32'h6, 32'h0000_8001, nb);
      tx(1, 0, 3'd1, 32'h6, 32'h0, nb);
      chk("t3_lh", w_dram_odata, 32'hFFFF_8001);
      tx(1, 0, 3'd5, 32'h6, 32'h0, nb);
      chk("t3_lhu", w_dram_odata, 32'h0000_8001);
      tx(1, 0, 3'd2, 32'h4, 32'h0, nb);
      chk("t3_lw", w_dram_odata, 32'h8001_0000);

      // index wraps modulo the array depth
      tx(1, 0, 3'd2, 32'h0000_4010, 32'h0, nb);
      chk("wrap_lw", w_dram_odata, 32'hA522_3344);

      // 4: load held high, back-to-back
      seq_val[0] = 32'h1111_1111;
      seq_val[1] = 32'h2222_2222;
      seq_val[2] = 32'h3333_3333;
      for (int k = 0; k < 3; k++)
         tx(0, 1, 3'd2, 32'(4 * k), seq_val[k], nb);
      @(negedge CLK);
      w_dram_le   = 1'b1;
      w_dram_ctrl = 3'd2;
      w_dram_addr = 32'h0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk("t4_busy_after_gap", {31'd0, w_dram_busy}, 32'd1);
         w_dram_addr = 32'(4 * (k + 1));
         nb = 0;
         while (w_dram_busy && nb < 20) begin
            nb++;
            @(negedge CLK);
         end
         chk("t4_busy_cycles", nb, 32'd3);
         chk("t4_odata", w_dram_odata, seq_val[k]);
         if (k == 2) w_dram_le = 1'b0;
      end
      @(negedge CLK);
      chk("t4_idle_after", {31'd0, w_dram_busy}, 32'd0);

      // 5: reset during a store
      tx(0, 1, 3'd2, 32'h20, 32'h1234_5678, nb);
      @(negedge CLK);
      w_dram_we_t  = 1'b1;
      w_dram_ctrl  = 3'd2;
      w_dram_addr  = 32'h20;
      w_dram_wdata = 32'hCAFE_F00D;
      @(negedge CLK);
      w_dram_we_t = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("t5_busy_after_rst", {31'd0, w_dram_busy}, 32'd0);
      chk("t5_odata_after_rst", w_dram_odata, 32'd0);
      tx(1, 0, 3'd2, 32'h20, 32'h0, nb);
      chk("t5_store_dropped", w_dram_odata, 32'h1234_5678);

      // 6: misalign sticky, read-before-write
      tx(0, 1, 3'd2, 32'h0, 32'h77, nb);
      chk("t6_mis_before", {31'd0, w_misalign}, 32'd0);
      tx(1, 0, 3'd2, 32'h2, 32'h0, nb);
      chk("t6_mis_set", {31'd0, w_misalign}, 32'd1);
      chk("t6_lw_rounded", w_dram_odata, 32'h77);
      tx(1, 1, 3'd2, 32'h0, 32'h55, nb);
      chk("t6_rbw_odata", w_dram_odata, 32'h77);
      tx(1, 0, 3'd2, 32'h0, 32'h0, nb);
      chk("t6_after_write", w_dram_odata, 32'h55);
      chk("t6_mis_sticky", {31'd0, w_misalign}, 32'd1);

      repeat (2) @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1);
   end
endmodule
